// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the MEM stage: byte/half/word access, little-endian lanes,
// sign/zero load extension, misalignment rejection, registered read port, post-reset clear sweep.
module data_memory_ctrl #(
  parameter int unsigned DEPTH          = 1024,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned IDX_W          = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        misaligned
);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  logic [31:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clear_idx_q, clear_idx_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             ready_q, ready_d;
  logic             mis_q, mis_d;

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             legal;
  logic             do_load, do_store, reject, clear_en;
  logic [31:0]      rd_word, load_data, wr_data;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [3:0]       wr_be;
  logic             unused_addr;

  // Upper address bits are ignored so accesses wrap modulo DEPTH words.
  assign word_idx    = address[IDX_W+1:2];
  assign lane        = address[1:0];
  assign unused_addr = ^address[31:IDX_W+2];

  always_comb begin
    legal = 1'b0;
    unique case (memSize)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~address[0];
      2'b10:   legal = (address[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign do_load  = ready_q & legal & memRead;
  assign do_store = ready_q & legal & memWrite;
  assign reject   = ready_q & ~legal & (memRead | memWrite);
  assign clear_en = (state_q == StClear);

  // Load path reads the pre-store contents, giving read-before-write on a combined access.
  assign rd_word  = mem[word_idx];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    unique case (memSize)
      2'b00:   load_data = {{24{~memUnsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~memUnsigned & half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes; byte enables pick which lanes land.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = writeData;
    unique case (memSize)
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{writeData[7:0]}};
      end
      2'b01: begin
        wr_be   = address[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{writeData[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = writeData;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem[clear_idx_q] <= '0;
    end else if (do_store) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    unique case (state_q)
      StClear: begin
        clear_idx_d = clear_idx_q + IDX_W'(1);
        if (clear_idx_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      StIdle:  state_d = StIdle;
      default: state_d = ResetState;
    endcase
    ready_d     = (state_d == StIdle);
    read_data_d = do_load ? load_data : read_data_q;
    mis_d       = reject;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ResetState;
      clear_idx_q <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      mis_q       <= mis_d;
    end
  end

  assign readData   = read_data_q;
  assign ready      = ready_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed plan steps plus random traffic against a byte-array model.
module tb_data_memory_ctrl;

  localparam int Depth = 16;
  localparam int Bytes = Depth * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memRead = 1'b0, memWrite = 1'b0, memUnsigned = 1'b0;
  logic [1:0]  memSize = 2'b00;
  logic [31:0] address = '0, writeData = '0;
  logic [31:0] rd_a, rd_b;
  logic        rdy_a, rdy_b, mis_a, mis_b;

  int checks = 0;
  int failures = 0;

  // Model state: memory as a flat little-endian byte array.
  logic [7:0]  mb [Bytes];
  logic [31:0] rd_m;
  logic        mis_m;
  int          sweep_left;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH(Depth), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .memSize(memSize),
    .memUnsigned(memUnsigned), .address(address), .writeData(writeData),
    .readData(rd_a), .ready(rdy_a), .misaligned(mis_a)
  );

  data_memory_ctrl #(.DEPTH(Depth), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .memSize(memSize),
    .memUnsigned(memUnsigned), .address(address), .writeData(writeData),
    .readData(rd_b), .ready(rdy_b), .misaligned(mis_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mload(input int unsigned a, input int n, input bit uns);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[(a + i) % Bytes];
    if (!uns && n < 4 && v[8*n-1]) begin
      for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  task automatic step(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd);
    int n;
    bit legal;
    bit rdy_pre;
    int unsigned ba;
    memRead = rd; memWrite = wr; memSize = sz; memUnsigned = uns;
    address = a; writeData = wd;
    n       = 1 << sz;
    legal   = (sz != 2'b11) && ((a % n) == 0);
    ba      = a % Bytes;
    rdy_pre = (sweep_left == 0);
    mis_m   = rdy_pre && (rd || wr) && !legal;
    if (rdy_pre && legal && rd) rd_m = mload(ba, n, uns);
    if (rdy_pre && legal && wr) begin
      for (int i = 0; i < n; i++) mb[(ba + i) % Bytes] = wd[8*i +: 8];
    end
    if (sweep_left > 0) sweep_left--;
    @(posedge clk);
    #1;
    chk("readData", rd_a, rd_m);
    chk("misaligned", {31'b0, mis_a}, {31'b0, mis_m});
    chk("ready", {31'b0, rdy_a}, {31'b0, sweep_left == 0});
  endtask

  // Asserts reset for one edge; outputs must clear asynchronously.
  task automatic apply_reset();
    rst = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    #1;
    rd_m = '0; mis_m = 1'b0; sweep_left = Depth;
    for (int i = 0; i < Bytes; i++) mb[i] = 8'h00;
    chk("rst_readData", rd_a, 32'h0);
    chk("rst_ready", {31'b0, rdy_a}, 32'h0);
    chk("rst_misaligned", {31'b0, mis_a}, 32'h0);
    chk("rst_readData_nc", rd_b, 32'h0);
    chk("rst_ready_nc", {31'b0, rdy_b}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_ready", {31'b0, rdy_a}, 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    #1;
    apply_reset();

    // Clear sweep with a store held high throughout; the store must be ignored.
    for (int i = 0; i < Depth; i++) begin
      step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF);
      if (i == 0) chk("nc_ready_first_edge", {31'b0, rdy_b}, 32'h1);
      if (i == Depth - 2) chk("sweep_ready_low", {31'b0, rdy_a}, 32'h0);
    end
    chk("sweep_ready_high", {31'b0, rdy_a}, 32'h1);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("clear_load0", rd_a, 32'h0);

    // Byte and half lanes.
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA1B2_C3D4);
    step(1'b0, 1'b1, 2'b00, 1'b0, 32'h42, 32'h0000_007F);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    chk("plan_word", rd_a, 32'hA17F_C3D4);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h43, 32'h0);
    chk("plan_sbyte", rd_a, 32'hFFFF_FFA1);
    step(1'b1, 1'b0, 2'b00, 1'b1, 32'h43, 32'h0);
    chk("plan_ubyte", rd_a, 32'h0000_00A1);
    step(1'b1, 1'b0, 2'b01, 1'b0, 32'h40, 32'h0);
    chk("plan_shalf", rd_a, 32'hFFFF_C3D4);
    step(1'b1, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
    chk("plan_uhalf", rd_a, 32'h0000_A17F);

    // Rejected accesses pulse misaligned for one cycle and change nothing.
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h41, 32'h0);
    chk("plan_mis_word", {31'b0, mis_a}, 32'h1);
    chk("plan_mis_hold", rd_a, 32'h0000_A17F);
    step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    chk("plan_mis_pulse", {31'b0, mis_a}, 32'h0);
    step(1'b0, 1'b1, 2'b01, 1'b0, 32'h43, 32'h0000_5555);
    chk("plan_mis_half", {31'b0, mis_a}, 32'h1);
    step(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    chk("plan_mis_size3", {31'b0, mis_a}, 32'h1);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    chk("plan_mem_unchanged", rd_a, 32'hA17F_C3D4);

    // Read-before-write and wrap.
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'd5);
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'd9);
    chk("plan_rbw_old", rd_a, 32'd5);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("plan_rbw_new", rd_a, 32'd9);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h44, 32'h1234_5678);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    chk("plan_wrap", rd_a, 32'h1234_5678);

    // Random traffic against the byte-array model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
    end

    // Reset mid-sweep restarts the sweep from word 0.
    apply_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    apply_reset();
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    chk("resweep_load", rd_a, 32'h0);

    // Without the clear sweep, contents survive reset.
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
    apply_reset();
    step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    chk("nc_ready_after_reset", {31'b0, rdy_b}, 32'h1);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("nc_persist", rd_b, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
